// File: rtl/seq_mult_4x4_pkg.sv
// rtl/seq_mult_4x4_pkg.sv - shared state encodings and widths for the sequential multiplier
package seq_mult_4x4_pkg;

    localparam int OP_W = 4;
    localparam int PROD_W = 2 * OP_W;
    localparam logic [1:0] ITER_LAST = 2'd3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_mult_4x4_if.sv
// rtl/seq_mult_4x4_if.sv - start/done handshake bundle between requester and multiplier
interface seq_mult_4x4_if;
    import seq_mult_4x4_pkg::*;

    logic              start;
    logic [OP_W-1:0]   a;
    logic [OP_W-1:0]   b;
    logic              ready;
    logic              done;
    logic [PROD_W-1:0] product;

    modport master (
        output start, a, b,
        input  ready, done, product
    );

    modport slave (
        input  start, a, b,
        output ready, done, product
    );

endinterface

// File: rtl/FourBit_Adder_HA.sv
// rtl/FourBit_Adder_HA.sv - four-bit ripple adder built from half-adder pairs
module FourBit_Adder_HA (
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] sum,
    output logic       carry
);

    logic [4:0] c;
    logic [3:0] p;
    logic [3:0] g;
    logic [3:0] h;

    assign c[0] = 1'b0;

    // Each bit is two half adders with their carries OR-ed into the next stage
    for (genvar i = 0; i < 4; i++) begin : g_bit
        assign p[i]     = a[i] ^ b[i];
        assign g[i]     = a[i] & b[i];
        assign sum[i]   = p[i] ^ c[i];
        assign h[i]     = p[i] & c[i];
        assign c[i + 1] = g[i] | h[i];
    end

    assign carry = c[4];

endmodule

// File: rtl/seq_mult_4x4.sv
// rtl/seq_mult_4x4.sv - 4x4 unsigned shift-and-add multiplier around one four-bit adder
module seq_mult_4x4
    import seq_mult_4x4_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    seq_mult_4x4_if.slave bus
);

    state_t          state;
    logic [OP_W-1:0] m;
    logic [OP_W-1:0] acc;
    logic [OP_W-1:0] q;
    logic [1:0]      cnt;
    logic            ready_r;
    logic            done_r;

    logic [OP_W-1:0] addend;
    logic [OP_W-1:0] s;
    logic            c;

    // Add the multiplicand only when the current multiplier bit is set
    always_comb begin
        addend = '0;
        if (q[0]) begin
            addend = m;
        end
    end

    FourBit_Adder_HA u_adder (
        .a     (acc),
        .b     (addend),
        .sum   (s),
        .carry (c)
    );

    // Control FSM plus datapath registers; carry shifts into acc so it is never lost
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            m       <= '0;
            acc     <= '0;
            q       <= '0;
            cnt     <= '0;
            ready_r <= 1'b1;
            done_r  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        m       <= bus.a;
                        q       <= bus.b;
                        acc     <= '0;
                        cnt     <= '0;
                        ready_r <= 1'b0;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    acc <= {c, s[OP_W-1:1]};
                    q   <= {s[0], q[OP_W-1:1]};
                    cnt <= cnt + 2'd1;
                    if (cnt == ITER_LAST) begin
                        done_r <= 1'b1;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    ready_r <= 1'b1;
                    state   <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready_r;
    assign bus.done    = done_r;
    assign bus.product = {acc, q};

endmodule

// File: tb/tb_seq_mult_4x4.sv
// tb/tb_seq_mult_4x4.sv - directed and exhaustive checks of the sequential multiplier
module tb_seq_mult_4x4;

    logic clk;
    logic rst_n;
    int   vectors;
    int   miscompares;
    int   done_cnt;
    int   cyc;

    seq_mult_4x4_if bus ();

    seq_mult_4x4 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count cycles and cycles with done high, sampled before each edge updates
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_mult(input logic [3:0] x, input logic [3:0] y,
                           input logic [7:0] exp, input string tag);
        int lat;
        check({tag, "_ready_idle"}, 16'(bus.ready), 16'd1);
        bus.start = 1'b1;
        bus.a     = x;
        bus.b     = y;
        tick();
        bus.start = 1'b0;
        bus.a     = ~x;
        bus.b     = ~y;
        check({tag, "_ready_busy"}, 16'(bus.ready), 16'd0);
        lat = 0;
        while (bus.done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 16'(lat), 16'd4);
        check({tag, "_product"}, 16'(bus.product), 16'(exp));
        tick();
        check({tag, "_done_width"}, 16'(bus.done), 16'd0);
        check({tag, "_ready_back"}, 16'(bus.ready), 16'd1);
        check({tag, "_held"}, 16'(bus.product), 16'(exp));
    endtask

    initial begin
        int d0;
        int t1;
        int lat;
        logic [7:0] pairs [256];
        logic [7:0] tmp;
        logic [7:0] ref_p;
        int j;

        vectors     = 0;
        miscompares = 0;
        done_cnt    = 0;
        cyc         = 0;
        bus.start   = 1'b0;
        bus.a       = 4'd0;
        bus.b       = 4'd0;
        rst_n       = 1'b0;

        // Reset
        tick();
        tick();
        rst_n = 1'b1;
        check("rst_ready", 16'(bus.ready), 16'd1);
        check("rst_done", 16'(bus.done), 16'd0);
        check("rst_product", 16'(bus.product), 16'h00);
        tick();
        check("idle_hold_ready", 16'(bus.ready), 16'd1);

        // Directed products
        do_mult(4'd9, 4'd6, 8'd54, "basic_9x6");
        do_mult(4'd15, 4'd15, 8'hE1, "carry_15x15");
        do_mult(4'd0, 4'd13, 8'd0, "zero_0x13");
        do_mult(4'd13, 4'd1, 8'd13, "one_13x1");

        // Start during RUN is ignored
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.a = 4'd7;
        bus.b = 4'd3;
        tick();
        bus.start = 1'b0;
        tick();
        bus.start = 1'b1;
        bus.a = 4'd2;
        bus.b = 4'd2;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        check("ign_latency", 16'(lat), 16'd2);
        check("ign_product", 16'(bus.product), 16'd21);
        for (int i = 0; i < 8; i++) tick();
        check("ign_one_done", 16'(done_cnt - d0), 16'd1);
        check("ign_held", 16'(bus.product), 16'd21);

        // Mid-operation asynchronous reset
        d0 = done_cnt;
        bus.start = 1'b1;
        bus.a = 4'd11;
        bus.b = 4'd11;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 16'(bus.ready), 16'd1);
        check("mid_rst_done", 16'(bus.done), 16'd0);
        check("mid_rst_product", 16'(bus.product), 16'd0);
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("mid_rst_no_done", 16'(done_cnt - d0), 16'd0);
        do_mult(4'd11, 4'd11, 8'd121, "after_rst_11x11");

        // Back-to-back with start held high
        bus.start = 1'b1;
        bus.a = 4'd3;
        bus.b = 4'd5;
        tick();
        bus.a = 4'd4;
        bus.b = 4'd4;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        t1 = cyc;
        check("b2b_first_product", 16'(bus.product), 16'd15);
        tick();
        lat = 0;
        while (bus.done !== 1'b1 && lat < 12) begin
            tick();
            lat++;
        end
        bus.start = 1'b0;
        check("b2b_spacing", 16'(cyc - t1), 16'd6);
        check("b2b_second_product", 16'(bus.product), 16'd16);
        tick();
        tick();
        check("b2b_idle", 16'(bus.ready), 16'd1);

        // Exhaustive sweep in shuffled order against a reference product
        for (int i = 0; i < 256; i++) pairs[i] = 8'(i);
        for (int i = 255; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            tmp = pairs[i];
            pairs[i] = pairs[j];
            pairs[j] = tmp;
        end
        for (int i = 0; i < 256; i++) begin
            ref_p = 8'(pairs[i][7:4] * pairs[i][3:0]);
            do_mult(pairs[i][7:4], pairs[i][3:0], ref_p,
                    $sformatf("sweep_%0dx%0d", pairs[i][7:4], pairs[i][3:0]));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/seq_mult_4x4.md
# seq_mult_4x4

Sequential 4x4 unsigned shift-and-add multiplier. It sits directly around the existing four-bit adder stage: it feeds the adder's operands every cycle and consumes its Sum/Carry outputs. Over four iterations it produces an 8-bit product behind a start/done handshake. It gives the arithmetic datapath a multiply operation without a combinational array multiplier.

## Interface
Parameters:
- none. Operand width is fixed at 4 to match the four-bit adder.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- start  input  1  request a multiply; sampled only while ready=1.
- a  input  4  multiplicand, captured on the accepted start.
- b  input  4  multiplier, captured on the accepted start.
- ready  output  1  high only in IDLE; a start is accepted only when ready=1.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  8  unsigned a*b; held stable from done until the next accepted start.

## Operation
- Internal registers:
  - m[3:0]: latched multiplicand.
  - acc[3:0]: upper partial product.
  - q[3:0]: multiplier shifting out, product low bits shifting in.
  - cnt[1:0]: iteration counter.
  - state.
- States:
  - IDLE: ready=1. On start=1, load m<=a, q<=b, acc<=0, cnt<=0, go to RUN. With start=0, hold.
  - RUN: one iteration per cycle.
    - Adder operands are acc and (q[0] ? m : 4'b0). Adder result is {c, s}.
    - Update acc<={c, s[3:1]} and q<={s[0], q[3:1]}.
    - Increment cnt. When cnt==3, go to DONE after this update.
  - DONE: done=1 for exactly this one cycle, then go to IDLE unconditionally.
- product = {acc, q}, driven from registers with no combinational path from inputs.
- Arithmetic:
  - All values are unsigned.
  - The adder carry is the 5th bit of each partial sum and is never dropped.
  - Maximum result is 15*15=225, which fits in 8 bits.
- Boundary conditions:
  - start while in RUN or DONE: ignored. Operands are not re-sampled and the in-flight result is unaffected.
  - start held high continuously: a new multiply is accepted on the first IDLE cycle after DONE.
  - a or b changing during RUN: no effect.
  - rst_n low at any time, including mid-RUN: state goes to IDLE immediately and asynchronously, all registers clear, and the partial result is discarded.

## Timing
- Reset values: ready=1, done=0, product=8'h00, state=IDLE, cnt=0.
- Cycle numbering (T is the edge at which start is sampled high in IDLE):
  - Edge T: operands loaded; ready drops to 0 after T.
  - Edges T+1 to T+4: four RUN iterations.
  - After edge T+4: state=DONE, done=1, product valid.
  - After edge T+5: state=IDLE, done=0, ready=1, product still held.
- Latency from accepted start to done high is 4 cycles. Throughput is one multiply per 6 cycles with start held high.
- The adder is purely combinational inside the RUN cycle. Its path must close within one clock period; there is no extra register stage.

## Structure
- Shared package or header mult_defs holds:
  - state encodings: IDLE=2'd0, RUN=2'd1, DONE=2'd2.
  - localparam OP_W=4.
  - localparam ITER_LAST=2'd3.
- Instantiate exactly one sub-module: the existing four-bit adder FourBit_Adder_HA, for the acc+operand sum. No second adder and no `*` operator.
- Keep the FSM and datapath registers in a single always block, with a separate combinational operand mux.

## Test plan
- Reset: assert rst_n=0 for 2 cycles, then release. Required: ready=1, done=0, product=8'h00.
- Basic: a=9, b=6, start pulse. Required: done exactly 4 cycles after the accept edge, product=8'd54, done high for 1 cycle only.
- Carry stress: a=15, b=15. Required: product=8'hE1. Also a=0, b=13 gives 0, and a=13, b=1 gives 13.
- Ignored start: during RUN of 7*3, pulse start with a=2, b=2. Required: product=8'd21 and only one done pulse.
- Mid-op reset: start 11*11, assert rst_n=0 at RUN cycle 2. Required: immediate IDLE, product=0, no done pulse. A subsequent 11*11 gives 121.
- Back-to-back: hold start=1 with operands 3*5, then 4*4. Required: done pulses 6 cycles apart with products 15 and 16. Exhaustive random-order sweep of all 256 operand pairs against a reference model.
